countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 185 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown timer with set/run/pause/done modes.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   tick_1hz   - one-cycle count-enable pulse, once per second
//   sw_set     - level, requests set mode
//   sel        - set-field select (0 = seconds, 1 = minutes)
//   key_up     - one-cycle pulse, increment selected field in SET
//   key_dn     - one-cycle pulse, decrement selected field in SET
//   key_start  - one-cycle pulse, start/pause toggle, alarm acknowledge
//   key_clr    - one-cycle pulse, clear value and return to IDLE
//   sec_l, sec_h, min_l, min_h - registered BCD digits of MM:SS
//   state      - IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4
//   running    - high only in RUN
//   done_pulse - one-cycle pulse on expiry
//   alarm      - high only in DONE
module countdown_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       sw_set,
    input  logic       sel,
    input  logic       key_up,
    input  logic       key_dn,
    input  logic       key_start,
    input  logic       key_clr,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic [2:0] state,
    output logic       running,
    output logic       done_pulse,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      st_q, st_n;
    logic [7:0]  sec_q, sec_n;   // {sec_h, sec_l}
    logic [7:0]  min_q, min_n;   // {min_h, min_l}
    logic [5:0]  cnt_q, cnt_n;   // ticks seen while in DONE
    logic        dp_q, dp_n;
    logic        run_q, alarm_q;

    // BCD pair 00..59 increment with wrap 59 -> 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // BCD pair 00..59 decrement with wrap 00 -> 59
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            sec_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
            dp_q    <= 1'b0;
            run_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            st_q    <= st_n;
            sec_q   <= sec_n;
            min_q   <= min_n;
            cnt_q   <= cnt_n;
            dp_q    <= dp_n;
            run_q   <= (st_n == RUN);
            alarm_q <= (st_n == DONE);
        end
    end

    always_comb begin
        st_n  = st_q;
        sec_n = sec_q;
        min_n = min_q;
        cnt_n = cnt_q;
        dp_n  = 1'b0;

        if (key_clr) begin
            st_n  = IDLE;
            sec_n = '0;
            min_n = '0;
            cnt_n = '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (sw_set)
                        st_n = SET;
                    else if (key_start && ({min_q, sec_q} != 16'h0000))
                        st_n = RUN;
                end
                SET: begin
                    if (!sw_set) begin
                        st_n = IDLE;
                    end else if (key_up ^ key_dn) begin
                        if (sel)
                            min_n = key_up ? bcd_inc(min_q) : bcd_dec(min_q);
                        else
                            sec_n = key_up ? bcd_inc(sec_q) : bcd_dec(sec_q);
                    end
                end
                RUN: begin
                    if (key_start) begin
                        st_n = PAUSE;
                    end else if (tick_1hz) begin
                        // Packed BCD compares numerically, so <= 1 catches 00:01
                        // (and guards an unreachable 00:00 in RUN).
                        if ({min_q, sec_q} <= 16'h0001) begin
                            st_n  = DONE;
                            sec_n = '0;
                            min_n = '0;
                            cnt_n = '0;
                            dp_n  = 1'b1;
                        end else begin
                            sec_n = bcd_dec(sec_q);
                            if (sec_q == 8'h00)
                                min_n = bcd_dec(min_q);
                        end
                    end
                end
                PAUSE: begin
                    if (sw_set)
                        st_n = SET;
                    else if (key_start)
                        st_n = RUN;
                end
                DONE: begin
                    sec_n = '0;
                    min_n = '0;
                    if (key_start) begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end else if (tick_1hz) begin
                        if (cnt_q == 6'd59) begin
                            st_n  = IDLE;
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt_q + 6'd1;
                        end
                    end
                end
                default: begin
                    st_n = IDLE;
                end
            endcase
        end
    end

    assign sec_l      = sec_q[3:0];
    assign sec_h      = sec_q[7:4];
    assign min_l      = min_q[3:0];
    assign min_h      = min_q[7:4];
    assign state      = st_q;
    assign running    = run_q;
    assign done_pulse = dp_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scoreboard bench for countdown_timer.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, sw_set, sel, key_up, key_dn, key_start, key_clr;
    logic [3:0] sec_l, sec_h, min_l, min_h;
    logic [2:0] state;
    logic       running, done_pulse, alarm;

    typedef struct packed {
        logic [3:0] mh, ml, sh, sl;
        logic [2:0] st;
        logic       run, dp, al;
    } obs_t;

    obs_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    countdown_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .sw_set     (sw_set),
        .sel        (sel),
        .key_up     (key_up),
        .key_dn     (key_dn),
        .key_start  (key_start),
        .key_clr    (key_clr),
        .sec_l      (sec_l),
        .sec_h      (sec_h),
        .min_l      (min_l),
        .min_h      (min_h),
        .state      (state),
        .running    (running),
        .done_pulse (done_pulse),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(int mm, int ss, int st, bit dp);
        obs_t o;
        o.mh  = 4'(mm / 10);
        o.ml  = 4'(mm % 10);
        o.sh  = 4'(ss / 10);
        o.sl  = 4'(ss % 10);
        o.st  = 3'(st);
        o.run = (st == 2);
        o.dp  = dp;
        o.al  = (st == 4);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {min_h, min_l, sec_h, sec_l, state, running, done_pulse, alarm};
        return o;
    endfunction

    task automatic compare_head();
        obs_t  e, o;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o = sample();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", t, o, e);
        end
    endtask

    // Expectation queued with the stimulus, compared after the next edge.
    task automatic chk(string t, obs_t e);
        sb_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        compare_head();
        tick_1hz  = 1'b0;
        key_up    = 1'b0;
        key_dn    = 1'b0;
        key_start = 1'b0;
        key_clr   = 1'b0;
    endtask

    // Compare without a clock edge (asynchronous behaviour).
    task automatic chk_now(string t, obs_t e);
        sb_q.push_back(e);
        tag_q.push_back(t);
        #1;
        compare_head();
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; sw_set = 1'b0; sel = 1'b0;
        key_up = 1'b0; key_dn = 1'b0; key_start = 1'b0; key_clr = 1'b0;
        #11;
        chk_now("reset", mk(0, 0, 0, 0));
        rst_n = 1'b1;

        key_start = 1'b1; chk("start_at_zero", mk(0, 0, 0, 0));
        key_up = 1'b1;    chk("up_in_idle",    mk(0, 0, 0, 0));
        tick_1hz = 1'b1;  chk("tick_in_idle",  mk(0, 0, 0, 0));

        // 03:59 load sequence
        sw_set = 1'b1; chk("enter_set", mk(0, 0, 1, 0));
        sel = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            key_up = 1'b1; chk("min_up", mk(i, 0, 1, 0));
        end
        sel = 1'b0;
        key_dn = 1'b1; chk("sec_dn_wrap", mk(3, 59, 1, 0));
        key_up = 1'b1; key_dn = 1'b1; chk("up_dn_same", mk(3, 59, 1, 0));
        key_up = 1'b1; chk("sec_up_wrap", mk(3, 0, 1, 0));
        sel = 1'b1;
        key_dn = 1'b1; chk("min_dn_2", mk(2, 0, 1, 0));
        key_dn = 1'b1; chk("min_dn_1", mk(1, 0, 1, 0));
        key_dn = 1'b1; chk("min_dn_0", mk(0, 0, 1, 0));
        key_dn = 1'b1; chk("min_dn_wrap", mk(59, 0, 1, 0));
        key_up = 1'b1; chk("min_up_wrap", mk(0, 0, 1, 0));
        tick_1hz = 1'b1; key_start = 1'b1; chk("set_ignores", mk(0, 0, 1, 0));

        // 00:03 run to expiry
        sel = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            key_up = 1'b1; chk("sec_up", mk(0, i, 1, 0));
        end
        sw_set = 1'b0;    chk("set_to_idle", mk(0, 3, 0, 0));
        key_start = 1'b1; chk("start_run",   mk(0, 3, 2, 0));
        tick_1hz = 1'b1;  chk("tick_02",     mk(0, 2, 2, 0));
        tick_1hz = 1'b1;  chk("tick_01",     mk(0, 1, 2, 0));
        tick_1hz = 1'b1;  chk("expire",      mk(0, 0, 4, 1));
        chk("done_pulse_drop", mk(0, 0, 4, 0));
        key_up = 1'b1;    chk("up_in_done",  mk(0, 0, 4, 0));
        sw_set = 1'b1;    chk("set_in_done", mk(0, 0, 4, 0));
        sw_set = 1'b0;

        // 60-tick auto clear
        for (int i = 1; i <= 60; i++) begin
            tick_1hz = 1'b1;
            chk("done_ticks", (i < 60) ? mk(0, 0, 4, 0) : mk(0, 0, 0, 0));
        end

        // Acknowledge inside the window
        sw_set = 1'b1;    chk("reload_set", mk(0, 0, 1, 0));
        key_up = 1'b1;    chk("load_01",    mk(0, 1, 1, 0));
        sw_set = 1'b0;    chk("idle_01",    mk(0, 1, 0, 0));
        key_start = 1'b1; chk("run_01",     mk(0, 1, 2, 0));
        tick_1hz = 1'b1;  chk("expire2",    mk(0, 0, 4, 1));
        for (int i = 0; i < 5; i++) begin
            tick_1hz = 1'b1; chk("done_hold", mk(0, 0, 4, 0));
        end
        key_start = 1'b1; chk("ack_alarm",  mk(0, 0, 0, 0));

        // 10:00 borrow chain and pause
        sw_set = 1'b1; sel = 1'b1; chk("set_10", mk(0, 0, 1, 0));
        for (int i = 1; i <= 10; i++) begin
            key_up = 1'b1; chk("min_load", mk(i, 0, 1, 0));
        end
        sw_set = 1'b0;    chk("idle_10",      mk(10, 0, 0, 0));
        key_start = 1'b1; chk("run_10",       mk(10, 0, 2, 0));
        tick_1hz = 1'b1;  chk("borrow_0959",  mk(9, 59, 2, 0));
        key_start = 1'b1; tick_1hz = 1'b1; chk("pause_wins", mk(9, 59, 3, 0));
        tick_1hz = 1'b1;  chk("pause_hold",   mk(9, 59, 3, 0));
        key_start = 1'b1; chk("resume",       mk(9, 59, 2, 0));
        sw_set = 1'b1; tick_1hz = 1'b1; chk("run_ign_set", mk(9, 58, 2, 0));
        sw_set = 1'b0;
        key_start = 1'b1; chk("pause2",       mk(9, 58, 3, 0));
        sw_set = 1'b1;    chk("pause_to_set", mk(9, 58, 1, 0));
        sw_set = 1'b0;    chk("set_idle2",    mk(9, 58, 0, 0));
        key_start = 1'b1; chk("run2",         mk(9, 58, 2, 0));
        key_start = 1'b1; chk("pause3",       mk(9, 58, 3, 0));
        key_clr = 1'b1; key_start = 1'b1; chk("clr_in_pause", mk(0, 0, 0, 0));

        // 05:17 then asynchronous reset mid-RUN
        sw_set = 1'b1; sel = 1'b1; chk("set_517", mk(0, 0, 1, 0));
        for (int i = 1; i <= 5; i++) begin
            key_up = 1'b1; chk("min_517", mk(i, 0, 1, 0));
        end
        sel = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            key_up = 1'b1; chk("sec_517", mk(5, i, 1, 0));
        end
        sw_set = 1'b0;    chk("idle_517", mk(5, 17, 0, 0));
        key_start = 1'b1; chk("run_517",  mk(5, 17, 2, 0));
        #2;
        rst_n = 1'b0;
        chk_now("async_reset", mk(0, 0, 0, 0));
        key_start = 1'b1; chk("reset_hold", mk(0, 0, 0, 0));
        rst_n = 1'b1;
        key_start = 1'b1; chk("post_reset_idle", mk(0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
